// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
//   state_e    : operating states of the control FSM
//   DIGIT_W    : width of one BCD display digit
//   SEC_LIMIT  : highest seconds value before carry into minutes
//   HUND_LIMIT : highest hundredths value before carry into seconds
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int SEC_LIMIT  = 59;
    localparam int HUND_LIMIT = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00.
//   clk, rst_n           : clock, asynchronous active-low reset
//   inc_i                : advance by one this clock
//   clr_i                : force 00 (wins over inc_i)
//   tens_o, ones_o       : current registered value
//   nxt_tens_o, nxt_ones_o : value that will be loaded on the next edge
//   carry_o              : inc_i while at MAX (wrap), feeds the next stage
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o,
    output logic [DIGIT_W-1:0] nxt_tens_o,
    output logic [DIGIT_W-1:0] nxt_ones_o,
    output logic               carry_o
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX % 10);

    logic [DIGIT_W-1:0] tens_q, ones_q;
    logic [DIGIT_W-1:0] tens_d, ones_d;
    logic               at_max;

    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    // Combinational carry so every stage of the chain moves on the same tick.
    assign carry_o = inc_i && at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc_i) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_W'(1);
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o     = tens_q;
    assign ones_o     = ones_q;
    assign nxt_tens_o = tens_d;
    assign nxt_ones_o = ones_d;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: synchronises the 100 Hz hundredths clock, counts
// MM:SS.hh in BCD and supports run/pause, clear and lap-freeze.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   hund_clk            : 100 Hz square wave, asynchronous to clk
//   start_stop, clear, lap : one-clk control pulses (priority clear > start_stop > lap)
//   min_*, sec_*, hs_*  : registered BCD display digits
//   running             : high in RUN and LAP
//   overflow            : one-clk pulse when MAX_MIN:59.99 wraps to 00:00.00
// Control pulses follow a single-cycle strobe protocol: each is sampled on
// exactly one rising clk edge; there is no back-pressure.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hund_clk,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] hs_tens,
    output logic [DIGIT_W-1:0] hs_ones,
    output logic               running,
    output logic               overflow
);

    localparam int DISP_W = 6 * DIGIT_W;

    // Two synchroniser stages, one history stage, registered rising-edge tick.
    logic sync1_q, sync2_q, sync3_q, tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= hund_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= sync2_q & ~sync3_q;
        end
    end

    state_e state_q, state_d;
    logic   clear_acc;
    logic   lap_entry;
    logic   count_en;

    always_comb begin
        state_d   = state_q;
        clear_acc = 1'b0;
        lap_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear)           clear_acc = 1'b1;
                else if (start_stop) state_d   = ST_RUN;
            end
            ST_PAUSE: begin
                if (clear) begin
                    clear_acc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // clear is not accepted while counting
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d   = ST_LAP;
                    lap_entry = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_stop)  state_d = ST_PAUSE;
                else if (lap)    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decided on the pre-transition state so a tick alongside a stop still counts.
    assign count_en = tick_q && ((state_q == ST_RUN) || (state_q == ST_LAP));

    logic [DIGIT_W-1:0] hs_t, hs_o, hs_nt, hs_no;
    logic [DIGIT_W-1:0] sc_t, sc_o, sc_nt, sc_no;
    logic [DIGIT_W-1:0] mn_t, mn_o, mn_nt, mn_no;
    logic               hs_carry, sc_carry, mn_carry;

    bcd_digit_counter #(.MAX(HUND_LIMIT)) u_hund (
        .clk(clk), .rst_n(rst_n), .inc_i(count_en), .clr_i(clear_acc),
        .tens_o(hs_t), .ones_o(hs_o), .nxt_tens_o(hs_nt), .nxt_ones_o(hs_no),
        .carry_o(hs_carry)
    );

    bcd_digit_counter #(.MAX(SEC_LIMIT)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc_i(hs_carry), .clr_i(clear_acc),
        .tens_o(sc_t), .ones_o(sc_o), .nxt_tens_o(sc_nt), .nxt_ones_o(sc_no),
        .carry_o(sc_carry)
    );

    bcd_digit_counter #(.MAX(MAX_MIN)) u_min (
        .clk(clk), .rst_n(rst_n), .inc_i(sc_carry), .clr_i(clear_acc),
        .tens_o(mn_t), .ones_o(mn_o), .nxt_tens_o(mn_nt), .nxt_ones_o(mn_no),
        .carry_o(mn_carry)
    );

    logic [DISP_W-1:0] live_q, live_d;
    logic [DISP_W-1:0] lap_q, lap_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic              running_q, overflow_q;

    assign live_q = {mn_t, mn_o, sc_t, sc_o, hs_t, hs_o};
    assign live_d = {mn_nt, mn_no, sc_nt, sc_no, hs_nt, hs_no};

    // The lap register captures the count as it stood when lap was pressed.
    always_comb begin
        lap_d = lap_q;
        if (clear_acc)      lap_d = '0;
        else if (lap_entry) lap_d = live_q;
    end

    // Display is loaded with the value it must show after this edge.
    assign disp_d = (state_d == ST_LAP) ? lap_d : live_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lap_q      <= '0;
            disp_q     <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lap_q      <= lap_d;
            disp_q     <= disp_d;
            running_q  <= (state_d == ST_RUN) || (state_d == ST_LAP);
            overflow_q <= mn_carry;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones, hs_tens, hs_ones} = disp_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n, hund_clk, start_stop, lap, clear;

  always #5 clk = ~clk;

  logic [3:0] a_mt, a_mo, a_st, a_so, a_ht, a_ho;
  logic       a_run, a_ovf;
  logic [3:0] b_mt, b_mo, b_st, b_so, b_ht, b_ho;
  logic       b_run, b_ovf;
  logic [23:0] disp_a, disp_b;

  assign disp_a = {a_mt, a_mo, a_st, a_so, a_ht, a_ho};
  assign disp_b = {b_mt, b_mo, b_st, b_so, b_ht, b_ho};

  stopwatch_core dut (
    .clk(clk), .rst_n(rst_n), .hund_clk(hund_clk),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .hs_tens(a_ht), .hs_ones(a_ho), .running(a_run), .overflow(a_ovf)
  );

  stopwatch_core #(.MAX_MIN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hund_clk(hund_clk),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .hs_tens(b_ht), .hs_ones(b_ho), .running(b_run), .overflow(b_ovf)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;
  mstate_e mst;
  int tot_a, tot_b, lap_a;
  logic [23:0] exp_q[$];
  logic [23:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, h;
    m = t / 6000;
    s = (t / 100) % 60;
    h = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [23:0] model_disp();
    return (mst == M_LAP) ? to_bcd(lap_a) : to_bcd(tot_a);
  endfunction

  function automatic void model_zero();
    tot_a = 0;
    tot_b = 0;
    lap_a = 0;
  endfunction

  function automatic void model_tick();
    if (mst == M_RUN || mst == M_LAP) begin
      tot_a = (tot_a + 1) % 360000;
      tot_b = (tot_b + 1) % 18000;
    end
  endfunction

  function automatic void model_ctl(input logic ss, input logic lp, input logic cl);
    case (mst)
      M_IDLE:  if (cl) model_zero(); else if (ss) mst = M_RUN;
      M_PAUSE: if (cl) begin mst = M_IDLE; model_zero(); end else if (ss) mst = M_RUN;
      M_RUN:   if (ss) mst = M_PAUSE; else if (lp) begin mst = M_LAP; lap_a = tot_a; end
      M_LAP:   if (ss) mst = M_PAUSE; else if (lp) mst = M_RUN;
      default: mst = M_IDLE;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // All drivers start and end on a falling clk edge.
  task automatic hpulse(input int hi, input int lo);
    hund_clk = 1'b1;
    repeat (hi) @(negedge clk);
    hund_clk = 1'b0;
    repeat (lo) @(negedge clk);
    model_tick();
  endtask

  task automatic ctl(input logic ss, input logic lp, input logic cl);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    model_ctl(ss, lp, cl);
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; hund_clk = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    mst = M_IDLE; model_zero();
    repeat (6) begin
      hund_clk = ~hund_clk;
      @(negedge clk);
    end
    exp_q.push_back(to_bcd(0));
    exp_q.push_back(to_bcd(0));
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL reset_disp_a: got %h expected %h", disp_a, exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_b !== exp_v) begin n_bad++; $display("FAIL reset_disp_b: got %h expected %h", disp_b, exp_v); end
    n_cmp++;
    if (a_run !== 1'b0 || a_ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got run=%b ovf=%b expected run=0 ovf=0", a_run, a_ovf);
    end
    // release with hund_clk high, then several edges: IDLE must not count
    hund_clk = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    hund_clk = 1'b0;
    repeat (3) @(negedge clk);
    repeat (3) hpulse(2, 2);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL idle_no_count: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b0) begin n_bad++; $display("FAIL idle_running: got %b expected 0", a_run); end
  endtask

  task automatic test_run_latency();
    ctl(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (a_run !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b expected 1", a_run); end
    exp_q.push_back(model_disp());
    hund_clk = 1'b1;
    repeat (3) @(negedge clk);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL latency_edge3: got %h expected %h", disp_a, exp_v); end
    @(negedge clk);
    model_tick();
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL latency_edge4: got %h expected %h", disp_a, exp_v); end
    hund_clk = 1'b0;
    repeat (2) @(negedge clk);
    repeat (99) hpulse(2, 2);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL run_one_second: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b1) begin n_bad++; $display("FAIL run_running: got %b expected 1", a_run); end
  endtask

  task automatic test_pause_clear();
    ctl(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (a_run !== 1'b0) begin n_bad++; $display("FAIL pause_running: got %b expected 0", a_run); end
    exp_q.push_back(model_disp());
    repeat (10) hpulse(2, 2);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL pause_hold: got %h expected %h", disp_a, exp_v); end
    ctl(1'b0, 1'b0, 1'b1);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL pause_clear: got %h expected %h", disp_a, exp_v); end
    ctl(1'b1, 1'b0, 1'b0);
    repeat (7) hpulse(2, 2);
    ctl(1'b0, 1'b0, 1'b1);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL run_clear_ignored: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b1) begin n_bad++; $display("FAIL run_clear_running: got %b expected 1", a_run); end
  endtask

  task automatic test_lap();
    int n;
    n = 537 - tot_a;
    repeat (n) hpulse(2, 2);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL lap_preload: got %h expected %h", disp_a, exp_v); end
    ctl(1'b0, 1'b1, 1'b0);
    exp_q.push_back(model_disp());
    repeat (25) hpulse(2, 2);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL lap_frozen: got %h expected %h", disp_a, exp_v); end
    repeat (25) hpulse(2, 2);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL lap_frozen_late: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b1) begin n_bad++; $display("FAIL lap_running: got %b expected 1", a_run); end
    ctl(1'b0, 1'b1, 1'b0);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL lap_release: got %h expected %h", disp_a, exp_v); end
    // LAP -> PAUSE shows the live stopped count, not the frozen one
    ctl(1'b0, 1'b1, 1'b0);
    repeat (3) hpulse(2, 2);
    ctl(1'b1, 1'b0, 1'b0);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL lap_to_pause: got %h expected %h", disp_a, exp_v); end
  endtask

  task automatic test_back_to_back();
    ctl(1'b1, 1'b0, 1'b0);
    repeat (5) hpulse(2, 2);
    // all three pulses land on the tick edge while in RUN
    hund_clk = 1'b1;
    repeat (3) @(negedge clk);
    start_stop = 1'b1; lap = 1'b1; clear = 1'b1;
    model_tick();
    model_ctl(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    hund_clk = 1'b0;
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL b2b_count: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b0) begin n_bad++; $display("FAIL b2b_paused: got %b expected 0", a_run); end
    // tick on the edge that leaves PAUSE must not count
    repeat (2) @(negedge clk);
    hund_clk = 1'b1;
    repeat (3) @(negedge clk);
    start_stop = 1'b1;
    model_tick();
    model_ctl(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start_stop = 1'b0;
    hund_clk = 1'b0;
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL resume_tick: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b1) begin n_bad++; $display("FAIL resume_running: got %b expected 1", a_run); end
    @(negedge clk);
    // asynchronous reset in the middle of counting
    repeat (4) hpulse(2, 2);
    hund_clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    mst = M_IDLE; model_zero();
    #1;
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL midreset_disp: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (a_run !== 1'b0 || a_ovf !== 1'b0) begin
      n_bad++; $display("FAIL midreset_flags: got run=%b ovf=%b expected run=0 ovf=0", a_run, a_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hund_clk = 1'b0;
    repeat (3) hpulse(2, 2);
    exp_q.push_back(model_disp());
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL postreset_idle: got %h expected %h", disp_a, exp_v); end
  endtask

  task automatic test_overflow();
    ctl(1'b1, 1'b0, 1'b0);
    repeat (17999) hpulse(1, 1);
    repeat (4) @(negedge clk);
    exp_q.push_back(to_bcd(tot_b));
    exp_q.push_back(to_bcd(tot_a));
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_b !== exp_v) begin n_bad++; $display("FAIL ovf_preload_b: got %h expected %h", disp_b, exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL ovf_preload_a: got %h expected %h", disp_a, exp_v); end
    hund_clk = 1'b1;
    repeat (4) @(negedge clk);
    model_tick();
    exp_q.push_back(to_bcd(tot_b));
    exp_q.push_back(to_bcd(tot_a));
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_b !== exp_v) begin n_bad++; $display("FAIL ovf_wrap_b: got %h expected %h", disp_b, exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (disp_a !== exp_v) begin n_bad++; $display("FAIL ovf_carry_a: got %h expected %h", disp_a, exp_v); end
    n_cmp++;
    if (b_ovf !== 1'b1 || b_run !== 1'b1) begin
      n_bad++; $display("FAIL ovf_pulse_b: got ovf=%b run=%b expected ovf=1 run=1", b_ovf, b_run);
    end
    n_cmp++;
    if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_none_a: got %b expected 0", a_ovf); end
    @(negedge clk);
    hund_clk = 1'b0;
    n_cmp++;
    if (b_ovf !== 1'b0 || b_run !== 1'b1) begin
      n_bad++; $display("FAIL ovf_one_clk_b: got ovf=%b run=%b expected ovf=0 run=1", b_ovf, b_run);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_run_latency();
    test_pause_clear();
    test_lap();
    test_back_to_back();
    test_overflow();
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59: the highest minutes value before wrap; legal range 1..99.
REQ-002 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port hund_clk, input, 1: divided 100 Hz square wave from the hundredths clock divider; asynchronous to clk in use.
REQ-005 SHALL have port start_stop, input, 1: one-clk pulse that toggles between run and stop.
REQ-006 SHALL have port clear, input, 1: one-clk pulse that zeroes the count.
REQ-007 SHALL have port lap, input, 1: one-clk pulse that freezes or releases the display.
REQ-008 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, hs_tens, hs_ones, each output, 4: BCD display digits.
REQ-009 SHALL have port running, output, 1: high in RUN and LAP.
REQ-010 SHALL have port overflow, output, 1: one-clk pulse on wrap.

Function
REQ-011 SHALL pass hund_clk through a 2-FF synchronizer, then a rising-edge detector, producing tick: one clk wide per hund_clk rising edge, with no tick on a falling edge.
REQ-012 SHALL assert tick on the 3rd clk rising edge after hund_clk is first sampled high; the count updates on the following edge, which is the 4th.
REQ-013 SHALL implement the states IDLE, RUN, PAUSE and LAP.
REQ-014 IDLE SHALL move to RUN on start_stop.
REQ-015 RUN SHALL move to PAUSE on start_stop and to LAP on lap.
REQ-016 LAP SHALL move to RUN on lap and to PAUSE on start_stop.
REQ-017 PAUSE SHALL move to RUN on start_stop.
REQ-018 clear SHALL move IDLE or PAUSE to IDLE.
REQ-019 SHALL advance the count on tick only when the current (pre-transition) state is RUN or LAP, so a tick coincident with start_stop in RUN still counts and one coincident with start_stop in IDLE/PAUSE does not.
REQ-020 SHALL count in BCD: hundredths 00..99, then seconds 00..59, then minutes 00..MAX_MIN, with each carry taking effect on the same tick.
REQ-021 SHALL wrap MAX_MIN:59.99 plus one tick to 00:00.00 and pulse overflow for exactly that clk; the state is unchanged.
REQ-022 SHALL treat simultaneous pulses with priority clear > start_stop > lap, and the lower-priority pulses are dropped.
REQ-023 SHALL ignore clear in RUN and LAP.
REQ-024 SHALL zero the count and the lap register on the edge where clear is accepted.
REQ-025 SHALL copy the live count into the lap register on entry to LAP.
REQ-026 SHALL drive the outputs from the lap register in LAP and from the live count otherwise; in PAUSE, including PAUSE entered from LAP, the outputs show the live stopped count.
REQ-027 SHALL register all outputs, with no combinational path from an input to an output.

Reset
REQ-028 On rst_n low, SHALL asynchronously force state IDLE, all digits 0, lap register 0, synchronizer and edge flops 0, running 0, overflow 0.
REQ-029 SHALL lose the count when reset is asserted mid-count; after release, no count until start_stop.
REQ-030 SHALL generate no spurious tick in the first clk after reset release even if hund_clk is high; only a later hund_clk rising edge counts.

Structure
REQ-031 A shared package stopwatch_pkg SHALL hold the state enum, the BCD digit width (4) and the seconds limit (59).
REQ-032 SHALL use one sub-module, bcd_digit_counter: a mod-N two-digit BCD counter with inc, clr, carry_out and tens/ones outputs, instantiated three times.

Verification
REQ-033 Reset with hund_clk toggling, then start_stop and 100 hund_clk edges -> display 00:01.00, running=1, and the first increment lands on the 4th clk after the first hund_clk high.
REQ-034 Run, then start_stop -> PAUSE; 10 more edges -> count unchanged; clear -> 00:00.00 and IDLE; clear in RUN -> ignored.
REQ-035 Run to 00:05.37, then lap -> outputs frozen at 00:05.37 while counting continues; 50 edges later, lap -> live 00:05.87.
REQ-036 With MAX_MIN=2, preload by running to 02:59.99, then one tick -> 00:00.00, overflow high for exactly 1 clk, still RUN.
REQ-037 In RUN, start_stop, lap and clear in the same cycle as tick -> tick counted, PAUSE, clear dropped; rst_n pulsed mid-count -> all zeros immediately and IDLE.
